// File: rtl/uart_rdata_sender.sv
// Formats a captured 64-bit dump word (or 32-bit PC) as ASCII hex text and
// streams it byte-by-byte to the UART transmitter over valid/ready.
module uart_rdata_sender #(
  parameter bit         UPPER_HEX = 1'b1,
  parameter logic [7:0] SEP_CHAR  = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdata_snd_start,
  input  logic [63:0] rdata_snd,
  input  logic        pc_print_sel,
  input  logic        abort,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        flushing_wq,
  output logic        snd_busy
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  char_idx_q, char_idx_d;
  logic [63:0] payload_q, payload_d;
  logic        mode_q, mode_d;

  logic [4:0]  last_idx;
  logic [4:0]  hi_idx;
  logic [2:0]  nib_pos;
  logic [2:0]  nib_sel;
  logic [31:0] word;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  cur_char;

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return (UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, n - 4'd10};
  endfunction

  // Characters 0-7 come from the low word; 9-16 (dump mode only) from the high word.
  always_comb begin
    hi_idx   = char_idx_q - 5'd9;
    nib_pos  = (char_idx_q < 5'd8) ? char_idx_q[2:0] : hi_idx[2:0];
    nib_sel  = 3'd7 - nib_pos;
    word     = (char_idx_q < 5'd8) ? payload_q[31:0] : payload_q[63:32];
    nibble   = word[{nib_sel, 2'b00} +: 4];
    hex_char = to_ascii(nibble);
    last_idx = mode_q ? 5'd9 : 5'd18;
  end

  always_comb begin
    cur_char = 8'h0A;
    if (char_idx_q < 5'd8) begin
      cur_char = hex_char;
    end else if (mode_q) begin
      cur_char = (char_idx_q == 5'd8) ? 8'h0D : 8'h0A;
    end else begin
      case (char_idx_q)
        5'd8:    cur_char = SEP_CHAR;
        5'd17:   cur_char = 8'h0D;
        5'd18:   cur_char = 8'h0A;
        default: cur_char = hex_char;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    char_idx_d = char_idx_q;
    payload_d  = payload_q;
    mode_d     = mode_q;
    case (state_q)
      IDLE: begin
        if (rdata_snd_start && !abort) begin
          state_d    = SEND;
          payload_d  = rdata_snd;
          mode_d     = pc_print_sel;
          char_idx_d = 5'd0;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tx_ready) begin
          char_idx_d = char_idx_q + 5'd1;
          if (char_idx_q == last_idx)
            state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      char_idx_q <= 5'd0;
      payload_q  <= 64'd0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      char_idx_q <= char_idx_d;
      payload_q  <= payload_d;
      mode_q     <= mode_d;
    end
  end

  // Outputs decode registered state only, so tx_data cannot move under backpressure.
  assign tx_valid    = (state_q == SEND);
  assign tx_data     = tx_valid ? cur_char : 8'h00;
  assign flushing_wq = (state_q == DONE) && !abort;
  assign snd_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rdata_sender.sv
// Randomized/directed bench for uart_rdata_sender: an uppercase and a lowercase
// instance run side by side against a string-formatting reference model.
module tb_uart_rdata_sender;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        rdata_snd_start;
  logic [63:0] rdata_snd;
  logic        pc_print_sel;
  logic        abort;
  logic        tx_ready;

  logic [7:0]  tx_data_u, tx_data_l;
  logic        tx_valid_u, tx_valid_l;
  logic        flush_u, flush_l;
  logic        busy_u, busy_l;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_rdata_sender #(.UPPER_HEX(1'b1), .SEP_CHAR(8'h20)) dut_up (
    .clk(clk), .rst(rst), .rdata_snd_start(rdata_snd_start), .rdata_snd(rdata_snd),
    .pc_print_sel(pc_print_sel), .abort(abort), .tx_data(tx_data_u), .tx_valid(tx_valid_u),
    .tx_ready(tx_ready), .flushing_wq(flush_u), .snd_busy(busy_u)
  );

  uart_rdata_sender #(.UPPER_HEX(1'b0), .SEP_CHAR(8'h20)) dut_lo (
    .clk(clk), .rst(rst), .rdata_snd_start(rdata_snd_start), .rdata_snd(rdata_snd),
    .pc_print_sel(pc_print_sel), .abort(abort), .tx_data(tx_data_l), .tx_valid(tx_valid_l),
    .tx_ready(tx_ready), .flushing_wq(flush_l), .snd_busy(busy_l)
  );

  // Reference: the line is simply the printf-style hex text of the word(s) plus CR LF.
  function automatic bq_t make_line(input logic [63:0] pl, input bit pc, input bit up);
    string s;
    bq_t   q;
    s = $sformatf("%08h", pl[31:0]);
    if (!pc) s = {s, " ", $sformatf("%08h", pl[63:32])};
    if (up) s = s.toupper();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid_u"}, tx_valid_u, 0);
    check({tag, "_valid_l"}, tx_valid_l, 0);
    check({tag, "_flush_u"}, flush_u, 0);
    check({tag, "_flush_l"}, flush_l, 0);
    check({tag, "_busy_u"}, busy_u, 0);
    check({tag, "_busy_l"}, busy_l, 0);
  endtask

  // bp: 0 = ready held high, 1 = 1 on / 3 off, 2 = random ready.
  task automatic run_line(input logic [63:0] pl, input bit pc, input int bp,
                          input int abort_at, input bit restart, input int rst_at);
    bq_t exp_u, exp_l;
    int  sent, cyc, len;
    bit  rdy, ab, rs;
    exp_u = make_line(pl, pc, 1'b1);
    exp_l = make_line(pl, pc, 1'b0);
    len   = exp_u.size();
    rdata_snd       = pl;
    pc_print_sel    = pc;
    rdata_snd_start = 1'b1;
    @(negedge clk);
    rdata_snd_start = 1'b0;
    rdata_snd       = {$urandom, $urandom};
    sent = 0;
    cyc  = 1;
    while (cyc < 300) begin
      check($sformatf("valid_u[%0d]", sent), tx_valid_u, 1);
      check($sformatf("valid_l[%0d]", sent), tx_valid_l, 1);
      check($sformatf("data_u[%0d]", sent), tx_data_u, exp_u[sent]);
      check($sformatf("data_l[%0d]", sent), tx_data_l, exp_l[sent]);
      check("flush_early", flush_u | flush_l, 0);
      check("busy_send", busy_u & busy_l, 1);
      rdy = (bp == 0) ? 1'b1 : (bp == 1) ? (cyc % 4 == 1) : 1'($urandom_range(0, 1));
      tx_ready = rdy;
      ab = (abort_at >= 0) && (sent == abort_at);
      rs = (rst_at >= 0) && (sent == rst_at);
      abort = ab;
      rst   = rs;
      if (restart && cyc == 3) begin
        rdata_snd_start = 1'b1;
        rdata_snd       = ~pl;
        pc_print_sel    = ~pc;
      end
      @(negedge clk);
      rdata_snd_start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      cyc++;
      if (rdy) sent++;
      if (ab || rs) begin
        tx_ready = 1'b0;
        check_idle(rs ? "rst_mid" : "abort");
        if (rs) begin
          check("rst_data_u", tx_data_u, 0);
          check("rst_data_l", tx_data_l, 0);
        end
        @(negedge clk);
        check_idle(rs ? "rst_after" : "abort_after");
        $display("line %h pc=%0d cut after %0d bytes (%s)", pl, pc, sent, rs ? "reset" : "abort");
        return;
      end
      if (sent == len) break;
    end
    if (cyc >= 300) check("cycle_budget", sent, len);
    check("flush_u", flush_u, 1);
    check("flush_l", flush_l, 1);
    check("done_valid", tx_valid_u | tx_valid_l, 0);
    check("done_busy", busy_u & busy_l, 1);
    if (bp == 0) check("start_to_flush", cyc, len + 1);
    tx_ready = 1'b0;
    @(negedge clk);
    check_idle("post_done");
    if (restart) begin
      @(negedge clk);
      check_idle("no_second_line");
    end
    $display("line %h pc=%0d bp=%0d: %0d bytes in %0d cycles", pl, pc, bp, sent, cyc);
  endtask

  initial begin
    rst = 1'b1;
    rdata_snd_start = 1'b0;
    rdata_snd = 64'd0;
    pc_print_sel = 1'b0;
    abort = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_data_u", tx_data_u, 0);
    check("reset_data_l", tx_data_l, 0);
    rst = 1'b0;
    @(negedge clk);

    run_line(64'h89ABCDEF_01234567, 1'b0, 0, -1, 1'b0, -1);
    run_line(64'hFFFFFFFF_DEADBEEF, 1'b1, 0, -1, 1'b0, -1);
    run_line({$urandom, $urandom}, 1'b0, 1, -1, 1'b0, -1);
    run_line({$urandom, $urandom}, 1'b0, 0, 5, 1'b0, -1);
    run_line({$urandom, $urandom}, 1'b0, 0, -1, 1'b0, -1);
    run_line({$urandom, $urandom}, 1'b0, 2, -1, 1'b1, -1);
    run_line({$urandom, $urandom}, 1'b1, 0, -1, 1'b0, 4);
    run_line({$urandom, $urandom}, 1'b1, 1, -1, 1'b0, -1);

    // abort wins over a simultaneous start in IDLE
    rdata_snd_start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    rdata_snd_start = 1'b0;
    abort = 1'b0;
    check_idle("abort_vs_start");
    $display("start with abort in idle: busy=%0d", busy_u);

    for (int i = 0; i < 6; i++)
      run_line({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 2), -1, 1'b0, -1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/uart_rdata_sender.md
Name: uart_rdata_sender

Overview:
- Transmit-side partner of the monitor's read/dump logic.
- Captures the 64-bit dump word (or PC value) on a start pulse and formats it as ASCII hex text.
- Feeds the text one byte at a time to the UART byte transmitter over a valid/ready handshake.
- Returns a one-cycle completion pulse (flushing_wq) that advances the dump sequencer to its next read.

Parameters:
- UPPER_HEX, 1: 1 = hex letters 'A'-'F' (0x41-0x46); 0 = 'a'-'f' (0x61-0x66).
- SEP_CHAR, 8'h20: separator byte emitted between the two 32-bit words in dump mode.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rdata_snd_start  input  1  one-cycle request to send the current word.
- rdata_snd  input  64  payload; [31:0] is the lower-address word, [63:32] the upper.
- pc_print_sel  input  1  1 = PC mode (send [31:0] only); sampled together with rdata_snd_start.
- abort  input  1  read_stop/pgm_stop; cancels the current line.
- tx_data  output  8  ASCII byte to the UART transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts the byte this cycle.
- flushing_wq  output  1  one-cycle pulse when the line is fully accepted.
- snd_busy  output  1  line in progress (state != IDLE).

Behaviour:
- Reset: tx_data=8'h00, tx_valid=0, flushing_wq=0, snd_busy=0. Internal state: IDLE, char_idx=0, payload register=0.
- Reset mid-line drops the line immediately; no flushing_wq pulse.
- States: IDLE, SEND, DONE.
- IDLE -> SEND on rdata_snd_start & ~abort.
  - On that cycle capture rdata_snd into a 64-bit register and pc_print_sel into a mode bit.
  - Clear char_idx.
  - Set line length to 10 if mode=1, else 19.
- Character map by char_idx:
  - Dump mode (19 chars): 0-7 = nibbles [31:28] down to [3:0] (MSB nibble first); 8 = SEP_CHAR; 9-16 = nibbles [63:60] down to [35:32]; 17 = 8'h0D; 18 = 8'h0A.
  - PC mode (10 chars): 0-7 = nibbles of [31:0], MSB first; 8 = 8'h0D; 9 = 8'h0A.
- Nibble to ASCII:
  - 0-9 -> 0x30-0x39.
  - 10-15 -> 'A'-'F' or 'a'-'f' per UPPER_HEX.
- SEND:
  - tx_valid=1; tx_data = map(char_idx), held stable while tx_valid & ~tx_ready.
  - On tx_ready, char_idx increments.
  - On tx_ready with char_idx = length-1, go to DONE.
- Latency: start seen at cycle N -> tx_valid=1 with the first char at cycle N+1 (registered output).
- Throughput: back-to-back bytes, one per cycle, when tx_ready is held high.
- DONE: tx_valid=0; flushing_wq=1 for exactly this cycle; next state IDLE.
- Minimum start-to-flush time: 11 cycles (PC mode) or 20 cycles (dump mode) with tx_ready tied high.
- abort in SEND or DONE:
  - Next state IDLE, tx_valid=0 next cycle, no flushing_wq.
  - A byte handshaken in the same cycle as abort is counted as sent; nothing further is issued.
- abort in IDLE together with rdata_snd_start: abort wins; stay IDLE.
- rdata_snd_start while not IDLE: ignored. The payload register is not updated and the current line is unaffected.
- rdata_snd_start in the same cycle as the DONE pulse: ignored (sequencer re-requests after flushing_wq).
- tx_ready while tx_valid=0: no effect.
- snd_busy = (state != IDLE).

Test Plan:
- Dump mode: rst 2 cycles; start with rdata_snd=64'h89ABCDEF_01234567, pc_print_sel=0, tx_ready=1 -> bytes "01234567 89ABCDEF" CR LF (19 bytes on consecutive cycles); flushing_wq high once, 20 cycles after start.
- PC mode with lowercase: UPPER_HEX=0; start with rdata_snd=64'hFFFF_FFFF_DEAD_BEEF, pc_print_sel=1 -> bytes "deadbeef" 0D 0A (10 bytes); upper word not sent.
- Backpressure: tx_ready toggles 1 cycle on / 3 off -> tx_data stable whenever tx_valid & ~tx_ready; byte order unchanged; exactly one flushing_wq pulse.
- Abort: assert abort after 5 bytes accepted -> tx_valid=0 next cycle; no flushing_wq; a new start then sends a full fresh line.
- Start ignored while busy: second start with a different payload while busy -> first line completes unchanged; no second line.
- Reset mid-line: assert rst mid-line -> outputs return to reset values next edge; no flushing_wq pulse.
